// File: rtl/ext_irq_ctrl.sv
// External interrupt controller: synchronises device lines, tracks edge/level pending
// state and presents one fixed-priority request at a time to the core via INT/INT_NUM.
module ext_irq_ctrl #(
    parameter int NUM_IRQ     = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_IRQ-1:0] irq_in,
    input  logic [NUM_IRQ-1:0] irq_en,
    input  logic [NUM_IRQ-1:0] irq_edge,
    input  logic               irq_ack,
    input  logic               irq_done,
    output logic               INT,
    output logic [2:0]         INT_NUM,
    output logic [NUM_IRQ-1:0] irq_pending,
    output logic               in_service
);

    typedef enum logic [1:0] {IDLE, REQ, SERVICE} state_t;

    state_t                                r_state;
    logic [SYNC_STAGES-1:0][NUM_IRQ-1:0]   r_sync;
    logic [NUM_IRQ-1:0]                    r_prev;
    logic [NUM_IRQ-1:0]                    r_pend;
    logic [NUM_IRQ-1:0]                    r_edge_q;
    logic                                  r_int;
    logic [2:0]                            r_int_num;
    logic                                  r_in_svc;

    logic [NUM_IRQ-1:0] w_s;
    logic [NUM_IRQ-1:0] w_elig;
    logic [NUM_IRQ-1:0] w_clr;
    logic [NUM_IRQ-1:0] w_pend_nxt;
    logic [2:0]         w_win;
    logic               w_ack_ok;

    assign w_s      = r_sync[SYNC_STAGES-1];
    assign w_elig   = r_pend & irq_en;
    assign w_ack_ok = (r_state == REQ) && irq_ack;

    // Lowest index wins: scan downwards so the last hit is the smallest index.
    always_comb begin
        w_win = 3'd0;
        for (int i = NUM_IRQ - 1; i >= 0; i--) begin
            if (w_elig[i]) w_win = 3'(i);
        end
    end

    always_comb begin
        w_clr = '0;
        if (w_ack_ok) w_clr[r_int_num] = 1'b1;
        for (int i = 0; i < NUM_IRQ; i++) begin
            if (irq_edge[i] != r_edge_q[i])
                w_pend_nxt[i] = 1'b0;
            else if (irq_edge[i])
                w_pend_nxt[i] = (w_s[i] & ~r_prev[i]) | (r_pend[i] & ~w_clr[i]);
            else
                w_pend_nxt[i] = w_s[i];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync   <= '0;
            r_prev   <= '0;
            r_pend   <= '0;
            r_edge_q <= '0;
        end else begin
            r_sync   <= {r_sync[SYNC_STAGES-2:0], irq_in};
            r_prev   <= w_s;
            r_pend   <= w_pend_nxt;
            r_edge_q <= irq_edge;
        end
    end

    // Ack is checked before withdraw so a claim in the same cycle is never lost.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= IDLE;
            r_int     <= 1'b0;
            r_int_num <= 3'd0;
            r_in_svc  <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (|w_elig) begin
                        r_int_num <= w_win;
                        r_int     <= 1'b1;
                        r_state   <= REQ;
                    end
                end
                REQ: begin
                    if (irq_ack) begin
                        r_int    <= 1'b0;
                        r_in_svc <= 1'b1;
                        r_state  <= SERVICE;
                    end else if (!w_elig[r_int_num]) begin
                        r_int   <= 1'b0;
                        r_state <= IDLE;
                    end
                end
                SERVICE: begin
                    if (irq_done) begin
                        r_in_svc <= 1'b0;
                        r_state  <= IDLE;
                    end
                end
                default: begin
                    r_int    <= 1'b0;
                    r_in_svc <= 1'b0;
                    r_state  <= IDLE;
                end
            endcase
        end
    end

    assign INT         = r_int;
    assign INT_NUM     = r_int_num;
    assign irq_pending = r_pend;
    assign in_service  = r_in_svc;

endmodule

// File: tb/tb_ext_irq_ctrl.sv
// Directed bench for ext_irq_ctrl: latency, priority, level withdraw, no-preempt,
// enable gating and asynchronous reset, with hand-computed expectations.
module tb_ext_irq_ctrl;

    logic       clk;
    logic       rst_n;
    logic [7:0] irq_in;
    logic [7:0] irq_en;
    logic [7:0] irq_edge;
    logic       irq_ack;
    logic       irq_done;
    logic       INT;
    logic [2:0] INT_NUM;
    logic [7:0] irq_pending;
    logic       in_service;

    int n_checks = 0;
    int n_pass   = 0;

    ext_irq_ctrl #(.NUM_IRQ(8), .SYNC_STAGES(2)) dut (
        .clk(clk), .rst_n(rst_n), .irq_in(irq_in), .irq_en(irq_en),
        .irq_edge(irq_edge), .irq_ack(irq_ack), .irq_done(irq_done),
        .INT(INT), .INT_NUM(INT_NUM), .irq_pending(irq_pending),
        .in_service(in_service)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one edge; inputs driven and outputs sampled 1ns after it.
    task automatic tick(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic pulse_ack();
        irq_ack = 1'b1; tick(); irq_ack = 1'b0;
    endtask

    task automatic pulse_done();
        irq_done = 1'b1; tick(); irq_done = 1'b0;
    endtask

    task automatic test_reset();
        n_checks++;
        if (INT !== 1'b0 || INT_NUM !== 3'd0 || irq_pending !== 8'h00 || in_service !== 1'b0)
            $display("FAIL reset: INT=%b NUM=%0d pend=%h svc=%b, want 0/0/00/0",
                     INT, INT_NUM, irq_pending, in_service);
        else n_pass++;
        rst_n = 1'b1;
        tick(2);
        n_checks++;
        if (INT !== 1'b0 || irq_pending !== 8'h00)
            $display("FAIL reset_release: INT=%b pend=%h, want 0/00", INT, irq_pending);
        else n_pass++;
    endtask

    task automatic test_edge_latency();
        irq_in[5] = 1'b1;            // edge k
        tick(3);
        n_checks++;
        if (INT !== 1'b0 || irq_pending !== 8'h20)
            $display("FAIL latency_k3: INT=%b pend=%h, want 0/20", INT, irq_pending);
        else n_pass++;
        tick();
        n_checks++;
        if (INT !== 1'b1 || INT_NUM !== 3'd5)
            $display("FAIL latency_k4: INT=%b NUM=%0d, want 1/5", INT, INT_NUM);
        else n_pass++;
        pulse_ack();
        n_checks++;
        if (INT !== 1'b0 || irq_pending !== 8'h00 || in_service !== 1'b1)
            $display("FAIL ack5: INT=%b pend=%h svc=%b, want 0/00/1", INT, irq_pending, in_service);
        else n_pass++;
        irq_in = 8'h00;
        pulse_done();
        n_checks++;
        if (in_service !== 1'b0 || INT !== 1'b0)
            $display("FAIL done5: svc=%b INT=%b, want 0/0", in_service, INT);
        else n_pass++;
        tick(3);
    endtask

    task automatic test_priority();
        irq_in = 8'h48;
        tick(4);
        n_checks++;
        if (INT !== 1'b1 || INT_NUM !== 3'd3 || irq_pending !== 8'h48)
            $display("FAIL prio36: INT=%b NUM=%0d pend=%h, want 1/3/48", INT, INT_NUM, irq_pending);
        else n_pass++;
        pulse_ack();
        n_checks++;
        if (irq_pending !== 8'h40 || in_service !== 1'b1)
            $display("FAIL prio_ack: pend=%h svc=%b, want 40/1", irq_pending, in_service);
        else n_pass++;
        pulse_done();
        n_checks++;
        if (INT !== 1'b0)
            $display("FAIL prio_done_same: INT=%b, want 0", INT);
        else n_pass++;
        tick();
        n_checks++;
        if (INT !== 1'b1 || INT_NUM !== 3'd6)
            $display("FAIL prio_next: INT=%b NUM=%0d, want 1/6", INT, INT_NUM);
        else n_pass++;
        pulse_ack();
        pulse_done();
        irq_in = 8'h00;
        tick(3);
    endtask

    task automatic test_level_withdraw();
        irq_edge = 8'hFB;
        tick(2);
        irq_in[2] = 1'b1;
        tick(4);
        n_checks++;
        if (INT !== 1'b1 || INT_NUM !== 3'd2 || irq_pending !== 8'h04)
            $display("FAIL level_req: INT=%b NUM=%0d pend=%h, want 1/2/04", INT, INT_NUM, irq_pending);
        else n_pass++;
        irq_in[2] = 1'b0;            // edge m
        tick(2);
        n_checks++;
        if (INT !== 1'b1)
            $display("FAIL level_hold: INT=%b, want 1", INT);
        else n_pass++;
        tick(2);
        n_checks++;
        if (INT !== 1'b0 || irq_pending !== 8'h00 || in_service !== 1'b0)
            $display("FAIL level_drop: INT=%b pend=%h svc=%b, want 0/00/0", INT, irq_pending, in_service);
        else n_pass++;
        pulse_ack();                 // idle: ignored
        tick();
        n_checks++;
        if (INT !== 1'b0 || in_service !== 1'b0)
            $display("FAIL stray_ack: INT=%b svc=%b, want 0/0", INT, in_service);
        else n_pass++;
        irq_edge = 8'hFF;
        tick(2);
    endtask

    task automatic test_no_preempt();
        irq_in[4] = 1'b1;
        tick(4);
        n_checks++;
        if (INT !== 1'b1 || INT_NUM !== 3'd4)
            $display("FAIL np_req: INT=%b NUM=%0d, want 1/4", INT, INT_NUM);
        else n_pass++;
        irq_in[1] = 1'b1;
        tick(6);
        n_checks++;
        if (INT !== 1'b1 || INT_NUM !== 3'd4 || irq_pending !== 8'h12)
            $display("FAIL np_hold: INT=%b NUM=%0d pend=%h, want 1/4/12", INT, INT_NUM, irq_pending);
        else n_pass++;
        pulse_ack();
        pulse_done();
        tick();
        n_checks++;
        if (INT !== 1'b1 || INT_NUM !== 3'd1)
            $display("FAIL np_next: INT=%b NUM=%0d, want 1/1", INT, INT_NUM);
        else n_pass++;
        pulse_ack();
        pulse_done();
        irq_in = 8'h00;
        tick(3);
    endtask

    task automatic test_enable();
        irq_en = 8'hFE;
        irq_in[0] = 1'b1;
        tick(5);
        n_checks++;
        if (INT !== 1'b0 || irq_pending !== 8'h01)
            $display("FAIL en_gated: INT=%b pend=%h, want 0/01", INT, irq_pending);
        else n_pass++;
        irq_en = 8'hFF;
        tick();
        n_checks++;
        if (INT !== 1'b1 || INT_NUM !== 3'd0)
            $display("FAIL en_open: INT=%b NUM=%0d, want 1/0", INT, INT_NUM);
        else n_pass++;
        pulse_ack();
        pulse_done();
        irq_in = 8'h00;
        tick(3);
    endtask

    task automatic test_async_reset();
        irq_in[7] = 1'b1;
        tick(4);
        n_checks++;
        if (INT !== 1'b1 || INT_NUM !== 3'd7)
            $display("FAIL ar_req: INT=%b NUM=%0d, want 1/7", INT, INT_NUM);
        else n_pass++;
        pulse_ack();
        n_checks++;
        if (in_service !== 1'b1)
            $display("FAIL ar_svc: svc=%b, want 1", in_service);
        else n_pass++;
        #2 rst_n = 1'b0;             // between clock edges
        #1;
        n_checks++;
        if (INT !== 1'b0 || INT_NUM !== 3'd0 || irq_pending !== 8'h00 || in_service !== 1'b0)
            $display("FAIL ar_async: INT=%b NUM=%0d pend=%h svc=%b, want 0/0/00/0",
                     INT, INT_NUM, irq_pending, in_service);
        else n_pass++;
        irq_in = 8'h00;
        tick();
        rst_n = 1'b1;
        pulse_done();
        tick(3);
        n_checks++;
        if (INT !== 1'b0 || in_service !== 1'b0 || irq_pending !== 8'h00)
            $display("FAIL ar_stray_done: INT=%b svc=%b pend=%h, want 0/0/00", INT, in_service, irq_pending);
        else n_pass++;
    endtask

    initial begin
        rst_n    = 1'b0;
        irq_in   = 8'h00;
        irq_en   = 8'hFF;
        irq_edge = 8'hFF;
        irq_ack  = 1'b0;
        irq_done = 1'b0;
        tick(3);
        test_reset();
        test_edge_latency();
        test_priority();
        test_level_withdraw();
        test_no_preempt();
        test_enable();
        test_async_reset();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
